iter_mult_csa: RTL and testbench

Parametrised iterative multiplier that splits operand A into NUM_SLICES slices and multiplies one slice by operand B per cycle. Each partial product is accumulated in carry-save form through a 3:2 compressor, then resolved by a single carry-propagate add. It generalises the fixed two-pass 64x64 compressor multiplier to any slice count and adds valid/ready handshakes on both sides. An optional signed mode is also available. It sits in the arithmetic datapath between the operand staging registers and the result consumer.

---
 rtl/iter_mult_pkg.sv | 10 +
 rtl/iter_mult_csa_csa_3to2.sv | 13 +
 rtl/iter_mult_csa.sv | 119 +++++++++++
 tb/tb_iter_mult_csa.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_pkg.sv
// iter_mult_pkg: shared state encoding, default widths and counter sizing for iter_mult_csa
package iter_mult_pkg;
  typedef enum logic [1:0] {IDLE, ITER, RESOLVE, DONE} state_t;
  localparam int A_W_DEF = 64;
  localparam int B_W_DEF = 64;
  localparam int SLICE_W_DEF = 16;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iter_mult_csa_csa_3to2.sv
// csa_3to2: 3:2 carry-save compressor, carry pre-shifted into its weight position
module csa_3to2 #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);
  assign o_sum = i_a ^ i_b ^ i_c;
  assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;
endmodule

// File: rtl/iter_mult_csa.sv
// iter_mult_csa: sliced iterative multiplier, carry-save accumulate then one CPA; ITER_MULT_SIGNED_EN adds signed mode
module iter_mult_csa
  import iter_mult_pkg::*;
#(
  parameter int A_WIDTH = A_W_DEF,
  parameter int B_WIDTH = B_W_DEF,
  parameter int SLICE_WIDTH = SLICE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [B_WIDTH-1:0]         in_b,
`ifdef ITER_MULT_SIGNED_EN
  input  logic                       in_signed,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] out_data,
  output logic                       busy
);
  localparam int P = A_WIDTH + B_WIDTH;
  localparam int NS = A_WIDTH / SLICE_WIDTH;
  localparam int KW = cnt_w(NS);
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);
  if (A_WIDTH % SLICE_WIDTH != 0) begin : g_bad_slice
    $error("iter_mult_csa: SLICE_WIDTH must divide A_WIDTH");
  end
  state_t r_state;
  logic [A_WIDTH-1:0] r_a;
  logic [P-1:0] r_b;
  logic [P-1:0] r_sum;
  logic [P-1:0] r_carry;
  logic [KW-1:0] r_k;
  logic w_in_sgn;
  logic w_sgn;
  logic w_top;
  logic [P-1:0] w_bext;
  logic [P-1:0] w_slice;
  logic [P-1:0] w_pp;
  logic [P-1:0] w_sum;
  logic [P-1:0] w_carry;
`ifdef ITER_MULT_SIGNED_EN
  logic r_sgn;
  assign w_in_sgn = in_signed;
  assign w_sgn = r_sgn;
`else
  assign w_in_sgn = 1'b0;
  assign w_sgn = 1'b0;
`endif
  // A shifts down and B shifts up each slice, so the current slice is always A's low bits
  always_comb begin
    w_top = r_k == K_LAST;
    w_bext = {{A_WIDTH{w_in_sgn & in_b[B_WIDTH-1]}}, in_b};
    w_slice = {{(P-SLICE_WIDTH){w_sgn & w_top & r_a[SLICE_WIDTH-1]}}, r_a[SLICE_WIDTH-1:0]};
    w_pp = w_slice * r_b;
  end
  csa_3to2 #(.WIDTH(P)) u_csa (
    .i_a(r_sum),
    .i_b(r_carry),
    .i_c(w_pp),
    .o_sum(w_sum),
    .o_carry(w_carry)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      out_data <= '0;
      r_k <= '0;
      r_sum <= '0;
      r_carry <= '0;
      r_a <= '0;
      r_b <= '0;
`ifdef ITER_MULT_SIGNED_EN
      r_sgn <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a <= in_a;
          r_b <= w_bext;
          r_sum <= '0;
          r_carry <= '0;
          r_k <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          r_state <= ITER;
`ifdef ITER_MULT_SIGNED_EN
          r_sgn <= in_signed;
`endif
        end
        ITER: begin
          r_sum <= w_sum;
          r_carry <= w_carry;
          r_a <= r_a >> SLICE_WIDTH;
          r_b <= r_b << SLICE_WIDTH;
          r_k <= r_k + 1'b1;
          if (r_k == K_LAST) r_state <= RESOLVE;
        end
        RESOLVE: begin
          out_data <= r_sum + r_carry;
          out_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mult_csa.sv
// tb_iter_mult_csa: scoreboard bench over SLICE_WIDTH 8/16/32/64, directed corners plus random vects
module tb_iter_mult_csa;
  typedef struct {
    logic [127:0] e;
    int acc;
  } exp_t;
`ifdef ITER_MULT_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif
  logic clk = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_done = 0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return s ? 128'(sa * sb) : {64'b0, a} * {64'b0, b};
  endfunction
  genvar g;
  for (g = 0; g < 4; g++) begin : gw
    localparam int SW = 8 << g;
    localparam int NS = 64 / SW;
    logic rst, in_valid, in_ready, out_valid, out_ready, busy, in_sg;
    logic [63:0] in_a, in_b;
    logic [127:0] out_data;
    bit rnd = 1'b0;
    bit seen = 1'b0;
    exp_t q[$];
    iter_mult_csa #(.A_WIDTH(64), .B_WIDTH(64), .SLICE_WIDTH(SW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_a(in_a),
      .in_b(in_b),
`ifdef ITER_MULT_SIGNED_EN
      .in_signed(in_sg),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .busy(busy)
    );
    function automatic string nm(input string s);
      return $sformatf("sw%0d %s", SW, s);
    endfunction
    task automatic set_ordy(input logic v);
      @(posedge clk);
      #1 out_ready = v;
    endtask
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic [127:0] e);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_sg = s;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk(nm("accept timeout"), in_ready, 1);
      else q.push_back('{e, cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_sg = 1'($urandom);
    endtask
    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk(nm("drain"), q.size(), 0);
    endtask
    task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
    endtask
    initial forever begin
      @(posedge clk);
      #1 if (rnd) out_ready = $urandom_range(0, 3) != 0;
    end
    initial forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected result 0x%0h want none", nm("spurious"), out_data);
          end else chk(nm("latency"), cyc - q[0].acc, NS + 1);
        end
        if (out_ready && q.size() != 0) begin
          chk(nm("data"), out_data, q[0].e);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
    initial begin
      logic [63:0] a, b;
      logic s;
      rst = 1'b1;
      in_valid = 1'b1;
      in_a = '1;
      in_b = '1;
      in_sg = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk(nm("rst in_ready"), in_ready, 1);
      chk(nm("rst out_valid"), out_valid, 0);
      chk(nm("rst out_data"), out_data, 0);
      chk(nm("rst busy"), busy, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk(nm("idle busy"), busy, 0);
      set_ordy(1'b1);
      issue('1, '1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      drain();
      issue(64'd2, 64'd3, 1'b0, 128'd6);
      drain();
`ifdef ITER_MULT_SIGNED_EN
      issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
      drain();
`endif
      issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1);
      drain();
      set_ordy(1'b0);
      issue(64'h1234, 64'h10, 1'b0, 128'h12340);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk(nm("hold valid"), out_valid, 1);
        chk(nm("hold data"), out_data, 128'h12340);
        chk(nm("hold in_ready"), in_ready, 0);
        chk(nm("hold busy"), busy, 1);
        in_valid = 1'b1;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
      end
      @(negedge clk);
      in_valid = 1'b0;
      set_ordy(1'b1);
      @(negedge clk);
      @(negedge clk);
      chk(nm("release valid"), out_valid, 0);
      chk(nm("release in_ready"), in_ready, 1);
      chk(nm("release busy"), busy, 0);
      set_ordy(1'b0);
      issue(64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F00D_CAFE, 1'b0,
            model(64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F00D_CAFE, 1'b0));
      @(negedge clk);
      chk(nm("mid busy"), busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk(nm("abort in_ready"), in_ready, 1);
      chk(nm("abort out_valid"), out_valid, 0);
      chk(nm("abort busy"), busy, 0);
      chk(nm("abort out_data"), out_data, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      set_ordy(1'b1);
      issue(64'd7, 64'd6, 1'b0, 128'd42);
      drain();
      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        a = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
        b = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
        s = SGN_EN && ($urandom_range(0, 1) == 1);
        issue(a, b, s, model(a, b, s));
      end
      drain();
      rnd = 1'b0;
      n_done++;
    end
  end
  initial begin
    int n = 0;
    while (n_done < 4 && n < 90000) begin
      @(posedge clk);
      n++;
    end
    chk("all blocks finished", n_done, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
